uart_packet_framer: RTL and testbench
=====================================

Name: uart_packet_framer

Overview:
- Sits directly upstream of the packet router.
- Parses the raw UART receive byte stream into framed packets. Frame format: magic byte, then a 16-bit big-endian length, then `length` payload bytes.
- Emits the payload as a valid/ready/last byte stream. The first payload byte is the router's tag byte.
- The UART side cannot be back-pressured. An internal FIFO absorbs router stalls, and whole packets that cannot fit are dropped.

Parameters:
- MAGIC, 8'h51, start-of-frame byte.
- FIFO_LOG2_DEPTH, 6, log2 of payload FIFO depth (DEPTH = 64 entries, each 8 data bits + 1 last bit).

Ports:
- clock  input  1  system clock; all state on rising edge.
- clear  input  1  asynchronous, active-high reset.
- uart_valid  input  1  one-cycle strobe: uart_data holds a received byte.
- uart_data  input  8  received byte.
- ready  input  1  downstream (router) accepts the current byte.
- valid  output  1  FIFO non-empty; data/last are meaningful.
- data  output  8  payload byte at FIFO head.
- last  output  1  head byte is the final byte of its packet.
- dropped_packets  output  8  count of discarded packets; wraps 255->0.

Behaviour:
- Reset (clear=1, asynchronous):
  - state=WAIT_MAGIC; FIFO read/write pointers and occupancy=0.
  - dropped_packets=0; valid=0; data=0; last=0.
  - Clear asserted mid-packet discards everything, including FIFO contents.
- Parser FSM advances only on cycles with uart_valid=1:
  - WAIT_MAGIC: byte==MAGIC -> LEN_HI; any other byte is ignored.
  - LEN_HI: latch byte as len[15:8] -> LEN_LO.
  - LEN_LO: form len = {len_hi, byte}.
    - len==0 -> WAIT_MAGIC. No output; not counted as a drop.
    - len <= free (free = DEPTH - occupancy, registered value at start of this cycle; a simultaneous pop is not credited) -> PAYLOAD with remaining=len.
    - otherwise -> DISCARD with remaining=len, and dropped_packets increments.
  - PAYLOAD: push {byte, last=(remaining==1)}; remaining--. When remaining==1 -> WAIT_MAGIC. A MAGIC value inside the payload is ordinary data.
  - DISCARD: nothing pushed; remaining--. When remaining==1 -> WAIT_MAGIC.
- Admission rule: free space only grows after admission, so an admitted packet never overflows the FIFO. Push never happens when full. Packets with len > DEPTH are always dropped.
- remaining counter: 16 bits.
- FIFO:
  - Standard circular buffer; pointers wrap modulo DEPTH.
  - Occupancy is FIFO_LOG2_DEPTH+1 bits.
  - Pop when valid & ready. Simultaneous push and pop leaves occupancy unchanged and is legal at full and at empty-plus-one.
  - Push-to-output latency is 1 cycle: a byte pushed in cycle N is at the head no earlier than cycle N+1. No fall-through.
- Outputs:
  - data/last are driven from the head entry when valid=1, and forced to 0 when empty.
  - Held stable while valid & !ready.
- dropped_packets is an 8-bit wrapping counter, incremented once per rejected header.

Decomposition:
- Shared package:
  - MAGIC default.
  - Parser state enum: WAIT_MAGIC, LEN_HI, LEN_LO, PAYLOAD, DISCARD.
  - Length field width constant (16).
- One sub-module: byte_fifo.
  - Parameters: width 9, FIFO_LOG2_DEPTH.
  - Ports: push, push_data, pop, head, empty, occupancy.
  - Same clock and asynchronous clear.
- The top level holds the parser FSM, length/remaining registers and drop counter.

Test Plan:
- Basic frame, ready=1: UART 51 00 03 01 AA BB -> output 01, AA, BB on consecutive cycles; last=1 only on BB; dropped_packets=0.
- Garbage and zero length: UART 00 7F 51 00 00 51 00 01 00 -> leading garbage ignored; the len=0 frame produces nothing; single byte 00 output with last=1; dropped_packets=0.
- Backpressure: ready=0 throughout a 5-byte frame (tag 00, payload 51 51 51 51), then ready=1 -> five bytes emitted in order; data and last held stable while stalled; last on the 5th byte only.
- Admission boundary, DEPTH=64, ready=0:
  - 60-byte packet, then a 4-byte packet -> second is accepted (free=4).
  - A further 1-byte packet -> dropped; dropped_packets=1; parser returns to WAIT_MAGIC after consuming that byte.
  - The next valid frame is parsed correctly once space frees.
- Oversize: header 51 01 00 (len=256) followed by 256 bytes containing 51 -> nothing output; dropped_packets=1; the following frame is parsed correctly.
- Reset mid-operation: assert clear during PAYLOAD with 10 bytes in the FIFO -> immediately valid=0, data=0, last=0, dropped_packets=0; a subsequent frame is parsed from WAIT_MAGIC.

Source files
------------

// File: rtl/uart_packet_framer_pkg.sv
// Shared definitions for the UART packet framer: start-of-frame byte,
// length-field width and the parser state encoding.
package uart_packet_framer_pkg;

    localparam logic [7:0] MAGIC_DEFAULT = 8'h51;
    localparam int         LEN_W         = 16;

    typedef enum logic [2:0] {
        WAIT_MAGIC,
        LEN_HI,
        LEN_LO,
        PAYLOAD,
        DISCARD
    } parser_state_e;

endpackage

// File: rtl/uart_packet_framer_byte_fifo.sv
// Circular-buffer FIFO holding payload entries {byte, last}.
// The head is presented only after the entry's write edge, so the
// push-to-head latency is one cycle and the FIFO never falls through.
module byte_fifo
    import uart_packet_framer_pkg::*;
#(
    parameter int WIDTH           = 9,
    parameter int FIFO_LOG2_DEPTH = 6
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [FIFO_LOG2_DEPTH:0]   occupancy
);

    localparam int DEPTH = 1 << FIFO_LOG2_DEPTH;
    localparam logic [FIFO_LOG2_DEPTH:0] DEPTH_CNT = (FIFO_LOG2_DEPTH + 1)'(DEPTH);

    logic [FIFO_LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2_DEPTH:0]   count_q, count_d;
    logic [WIDTH-1:0]           mem_q [DEPTH];

    logic full;
    logic do_push;
    logic do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_CNT);
    assign do_pop    = pop & ~empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push   = push & (~full | do_pop);
    assign occupancy = count_q;
    assign head      = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer and occupancy values from the push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; clear empties the FIFO.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_packet_framer.sv
// UART packet framer: parses MAGIC / 16-bit big-endian length / payload
// frames from the UART byte stream and emits the payload as a
// valid/ready/last stream. Packets that do not fit in the free FIFO space
// at header time are consumed and discarded, and counted.
module uart_packet_framer
    import uart_packet_framer_pkg::*;
#(
    parameter logic [7:0] MAGIC           = MAGIC_DEFAULT,
    parameter int         FIFO_LOG2_DEPTH = 6
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       uart_valid,
    input  logic [7:0] uart_data,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] data,
    output logic       last,
    output logic [7:0] dropped_packets
);

    localparam int DEPTH = 1 << FIFO_LOG2_DEPTH;
    localparam logic [FIFO_LOG2_DEPTH:0] DEPTH_CNT = (FIFO_LOG2_DEPTH + 1)'(DEPTH);

    parser_state_e     state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [7:0]        dropped_q, dropped_d;

    logic [LEN_W-1:0]           len_full;
    logic [FIFO_LOG2_DEPTH:0]   occupancy;
    logic [FIFO_LOG2_DEPTH:0]   free_space;
    logic                       fifo_push;
    logic [8:0]                 fifo_push_data;
    logic [8:0]                 fifo_head;
    logic                       fifo_empty;
    logic                       fifo_pop;

    assign len_full   = {len_hi_q, uart_data};
    // Free space is taken from the registered occupancy; a pop in the
    // header cycle is deliberately not credited.
    assign free_space = DEPTH_CNT - occupancy;

    // Parser next-state, length/remaining bookkeeping and push generation.
    always_comb begin
        state_d        = state_q;
        len_hi_d       = len_hi_q;
        remaining_d    = remaining_q;
        dropped_d      = dropped_q;
        fifo_push      = 1'b0;
        fifo_push_data = {uart_data, (remaining_q == LEN_W'(1))};
        if (uart_valid) begin
            case (state_q)
                WAIT_MAGIC: begin
                    if (uart_data == MAGIC) begin
                        state_d = LEN_HI;
                    end
                end
                LEN_HI: begin
                    len_hi_d = uart_data;
                    state_d  = LEN_LO;
                end
                LEN_LO: begin
                    remaining_d = len_full;
                    if (len_full == '0) begin
                        state_d = WAIT_MAGIC;
                    end else if (len_full <= LEN_W'(free_space)) begin
                        state_d = PAYLOAD;
                    end else begin
                        state_d   = DISCARD;
                        dropped_d = dropped_q + 8'd1;
                    end
                end
                PAYLOAD: begin
                    fifo_push   = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = WAIT_MAGIC;
                    end
                end
                DISCARD: begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = WAIT_MAGIC;
                    end
                end
                default: state_d = WAIT_MAGIC;
            endcase
        end
    end

    // Parser and counter registers; clear returns to hunting for MAGIC.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= WAIT_MAGIC;
            len_hi_q    <= '0;
            remaining_q <= '0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            remaining_q <= remaining_d;
            dropped_q   <= dropped_d;
        end
    end

    byte_fifo #(
        .WIDTH           (9),
        .FIFO_LOG2_DEPTH (FIFO_LOG2_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .clear     (clear),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    assign valid           = ~fifo_empty;
    assign fifo_pop        = valid & ready;
    assign data            = fifo_head[8:1];
    assign last            = fifo_head[0];
    assign dropped_packets = dropped_q;

endmodule

// File: tb/tb_uart_packet_framer.sv
// Directed bench for uart_packet_framer: basic framing, garbage and zero
// length, backpressure, admission boundary, oversize drop and mid-packet clear.
module tb_uart_packet_framer;

    logic       clock = 1'b0;
    logic       clear;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [7:0] dropped_packets;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_packet_framer dut (
        .clock           (clock),
        .clear           (clear),
        .uart_valid      (uart_valid),
        .uart_data       (uart_data),
        .ready           (ready),
        .valid           (valid),
        .data            (data),
        .last            (last),
        .dropped_packets (dropped_packets)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        uart_valid = 1'b1;
        uart_data  = b;
        tick();
        uart_valid = 1'b0;
        uart_data  = 8'h00;
    endtask

    task automatic send_hdr(input logic [15:0] len);
        send(8'h51);
        send(len[15:8]);
        send(len[7:0]);
    endtask

    initial begin
        int seen;
        clear      = 1'b1;
        uart_valid = 1'b0;
        uart_data  = 8'h00;
        ready      = 1'b0;
        #12;
        chk("reset_valid",   {31'd0, valid}, 32'd0);
        chk("reset_data",    {24'd0, data}, 32'd0);
        chk("reset_last",    {31'd0, last}, 32'd0);
        chk("reset_dropped", {24'd0, dropped_packets}, 32'd0);
        tick();
        clear = 1'b0;

        // Basic frame with ready held high.
        ready = 1'b1;
        send_hdr(16'd3);
        chk("basic_pre_valid", {31'd0, valid}, 32'd0);
        send(8'h01);
        chk("basic_b0_valid", {31'd0, valid}, 32'd1);
        chk("basic_b0_data",  {24'd0, data}, 32'h01);
        chk("basic_b0_last",  {31'd0, last}, 32'd0);
        send(8'hAA);
        chk("basic_b1_data",  {24'd0, data}, 32'hAA);
        chk("basic_b1_last",  {31'd0, last}, 32'd0);
        send(8'hBB);
        chk("basic_b2_data",  {24'd0, data}, 32'hBB);
        chk("basic_b2_last",  {31'd0, last}, 32'd1);
        tick();
        chk("basic_drained",  {31'd0, valid}, 32'd0);
        chk("basic_dropped",  {24'd0, dropped_packets}, 32'd0);

        // Garbage, then a zero-length frame, then a one-byte frame.
        send(8'h00);
        send(8'h7F);
        send_hdr(16'd0);
        tick();
        chk("zero_len_no_out", {31'd0, valid}, 32'd0);
        send_hdr(16'd1);
        send(8'h00);
        chk("one_byte_valid", {31'd0, valid}, 32'd1);
        chk("one_byte_data",  {24'd0, data}, 32'h00);
        chk("one_byte_last",  {31'd0, last}, 32'd1);
        tick();
        chk("one_byte_drained", {31'd0, valid}, 32'd0);
        chk("zero_len_dropped", {24'd0, dropped_packets}, 32'd0);

        // Backpressure: whole frame buffered while stalled, then released.
        ready = 1'b0;
        send_hdr(16'd5);
        send(8'h00);
        for (int k = 0; k < 4; k++) send(8'h51);
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", {31'd0, valid}, 32'd1);
            chk("stall_data",  {24'd0, data}, 32'h00);
            chk("stall_last",  {31'd0, last}, 32'd0);
            tick();
        end
        ready = 1'b1;
        tick();
        for (int k = 1; k < 5; k++) begin
            chk("bp_data", {24'd0, data}, 32'h51);
            chk("bp_last", {31'd0, last}, (k == 4) ? 32'd1 : 32'd0);
            tick();
        end
        chk("bp_drained", {31'd0, valid}, 32'd0);

        // Admission boundary: 60 + 4 fill the FIFO exactly; a 1-byte packet is dropped.
        ready = 1'b0;
        send_hdr(16'd60);
        for (int k = 0; k < 60; k++) send(8'(8'h10 + k));
        send_hdr(16'd4);
        for (int k = 0; k < 4; k++) send(8'(8'hE0 + k));
        chk("adm_fit_dropped", {24'd0, dropped_packets}, 32'd0);
        send_hdr(16'd1);
        chk("adm_full_dropped", {24'd0, dropped_packets}, 32'd1);
        send(8'h51);
        chk("adm_head_kept", {24'd0, data}, 32'h10);
        ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            chk("adm_drain_valid", {31'd0, valid}, 32'd1);
            chk("adm_drain_data",  {24'd0, data}, (k < 60) ? 32'(8'h10 + k) : 32'(8'hE0 + k - 60));
            chk("adm_drain_last",  {31'd0, last}, (k == 59 || k == 63) ? 32'd1 : 32'd0);
            tick();
        end
        chk("adm_empty", {31'd0, valid}, 32'd0);
        send_hdr(16'd2);
        send(8'hC1);
        chk("adm_next_d0", {24'd0, data}, 32'hC1);
        chk("adm_next_l0", {31'd0, last}, 32'd0);
        send(8'hC2);
        chk("adm_next_d1", {24'd0, data}, 32'hC2);
        chk("adm_next_l1", {31'd0, last}, 32'd1);
        tick();

        // Oversize packet after a fresh clear.
        clear = 1'b1;
        #2;
        clear = 1'b0;
        tick();
        ready = 1'b1;
        send_hdr(16'd256);
        chk("over_dropped", {24'd0, dropped_packets}, 32'd1);
        seen = 0;
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            if (valid) seen++;
        end
        chk("over_no_out", 32'(seen), 32'd0);
        send_hdr(16'd2);
        send(8'h5A);
        chk("over_next_d0", {24'd0, data}, 32'h5A);
        send(8'hA5);
        chk("over_next_d1", {24'd0, data}, 32'hA5);
        chk("over_next_l1", {31'd0, last}, 32'd1);
        tick();
        chk("over_dropped_end", {24'd0, dropped_packets}, 32'd1);

        // Clear in the middle of a payload with 10 bytes buffered.
        ready = 1'b0;
        send_hdr(16'd20);
        for (int k = 0; k < 10; k++) send(8'(8'h30 + k));
        chk("mid_pre_valid", {31'd0, valid}, 32'd1);
        clear = 1'b1;
        #1;
        chk("mid_clr_valid",   {31'd0, valid}, 32'd0);
        chk("mid_clr_data",    {24'd0, data}, 32'd0);
        chk("mid_clr_last",    {31'd0, last}, 32'd0);
        chk("mid_clr_dropped", {24'd0, dropped_packets}, 32'd0);
        tick();
        clear = 1'b0;
        ready = 1'b1;
        send_hdr(16'd1);
        send(8'h77);
        chk("post_clr_valid", {31'd0, valid}, 32'd1);
        chk("post_clr_data",  {24'd0, data}, 32'h77);
        chk("post_clr_last",  {31'd0, last}, 32'd1);
        tick();
        chk("post_clr_drained", {31'd0, valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
